// File: rtl/keypad_entry_buffer.sv
// Keypad front end: debounces scanner key codes into single press events, keeps an
// 8-digit right-aligned entry buffer and time-multiplexes it onto the 7-segment stage.
module keypad_entry_buffer #(
    parameter int DEBOUNCE = 16,
    parameter int SCAN_DIV = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] key_code,
    input  logic       key_valid,
    output logic [7:0] light_code,
    output logic [3:0] bcd,
    output logic       blank,
    output logic       dp_out,
    output logic       key_accept,
    output logic       overflow,
    output logic [3:0] digit_count
);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_DB,
        HELD,
        RELEASE_DB
    } state_t;

    localparam logic [15:0] DbLast   = 16'(DEBOUNCE - 1);
    localparam logic [15:0] ScanLast = 16'(SCAN_DIV - 1);

    state_t           state_q;
    logic [15:0]      dbCnt_q;
    logic [3:0]       keyCode_q;
    logic [7:0][3:0]  digits_q;
    logic [3:0]       count_q;
    logic [15:0]      scanCnt_q;
    logic [2:0]       scanIdx_q;
    logic [2:0]       scanIdx_d;
    logic             pressDone;

    // The press is accepted on the edge that completes a full stable debounce window.
    assign pressDone = (state_q == PRESS_DB) && key_valid &&
                       (key_code == keyCode_q) && (dbCnt_q == DbLast);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            dbCnt_q    <= '0;
            keyCode_q  <= '0;
            key_accept <= 1'b0;
        end else begin
            key_accept <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (key_valid) begin
                        keyCode_q <= key_code;
                        dbCnt_q   <= '0;
                        state_q   <= PRESS_DB;
                    end
                end
                PRESS_DB: begin
                    if (!key_valid || (key_code != keyCode_q)) begin
                        dbCnt_q <= '0;
                        state_q <= IDLE;
                    end else if (pressDone) begin
                        dbCnt_q    <= '0;
                        state_q    <= HELD;
                        key_accept <= 1'b1;
                    end else begin
                        dbCnt_q <= dbCnt_q + 16'd1;
                    end
                end
                HELD: begin
                    if (!key_valid) begin
                        dbCnt_q <= '0;
                        state_q <= RELEASE_DB;
                    end
                end
                RELEASE_DB: begin
                    if (key_valid) begin
                        dbCnt_q <= '0;
                        state_q <= HELD;
                    end else if (dbCnt_q == DbLast) begin
                        dbCnt_q <= '0;
                        state_q <= IDLE;
                    end else begin
                        dbCnt_q <= dbCnt_q + 16'd1;
                    end
                end
                default: begin
                    dbCnt_q <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Position 0 holds the newest digit; entries shift towards position 7.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            digits_q <= '0;
            count_q  <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= 1'b0;
            if (pressDone) begin
                if (keyCode_q <= 4'd9) begin
                    if (count_q < 4'd8) begin
                        digits_q <= {digits_q[6:0], keyCode_q};
                        count_q  <= count_q + 4'd1;
                    end else begin
                        overflow <= 1'b1;
                    end
                end else if (keyCode_q == 4'd10) begin
                    if (count_q != 4'd0) begin
                        digits_q <= {4'h0, digits_q[7:1]};
                        count_q  <= count_q - 4'd1;
                    end
                end else if (keyCode_q == 4'd11) begin
                    digits_q <= '0;
                    count_q  <= '0;
                end
            end
        end
    end

    assign digit_count = count_q;

    always_comb begin
        scanIdx_d = scanIdx_q;
        if (scanCnt_q == ScanLast) begin
            scanIdx_d = scanIdx_q + 3'd1;
        end
    end

    // Display registers use the new slot index but the buffer as it stood before this edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scanCnt_q  <= '0;
            scanIdx_q  <= '0;
            light_code <= 8'h01;
            bcd        <= 4'hF;
            blank      <= 1'b1;
            dp_out     <= 1'b0;
        end else begin
            scanCnt_q  <= (scanCnt_q == ScanLast) ? 16'd0 : scanCnt_q + 16'd1;
            scanIdx_q  <= scanIdx_d;
            light_code <= 8'b1 << scanIdx_d;
            if ({1'b0, scanIdx_d} < count_q) begin
                bcd   <= digits_q[scanIdx_d];
                blank <= 1'b0;
            end else begin
                bcd   <= 4'hF;
                blank <= 1'b1;
            end
            dp_out <= (scanIdx_d == 3'd0) && (count_q == 4'd8);
        end
    end

endmodule

// File: tb/tb_keypad_entry_buffer.sv
// Bench for keypad_entry_buffer: every cycle is compared with a press/release run-length
// model, a queue-based entry buffer and a time-derived scan position.
module tb_keypad_entry_buffer;

    localparam int D  = 4;
    localparam int SD = 4;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic [3:0] key_code  = 4'd0;
    logic       key_valid = 1'b0;
    logic [7:0] light_code;
    logic [3:0] bcd;
    logic       blank;
    logic       dp_out;
    logic       key_accept;
    logic       overflow;
    logic [3:0] digit_count;

    keypad_entry_buffer #(
        .DEBOUNCE(D),
        .SCAN_DIV(SD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_code   (key_code),
        .key_valid  (key_valid),
        .light_code (light_code),
        .bcd        (bcd),
        .blank      (blank),
        .dp_out     (dp_out),
        .key_accept (key_accept),
        .overflow   (overflow),
        .digit_count(digit_count)
    );

    always #5 clk = ~clk;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [19:0] expVec;
    logic [19:0] dutVec;
    assign dutVec = {light_code, bcd, blank, dp_out, key_accept, overflow, digit_count};

    int         bufQ[$];
    bit         armed;
    int         run;
    int         low;
    int         edges;
    logic [3:0] runCode;
    bit         stimRst[$];
    bit         stimValid[$];
    logic [3:0] stimCode[$];

    task automatic addCycles(input bit r, input bit v, input logic [3:0] c, input int n);
        for (int i = 0; i < n; i++) begin
            stimRst.push_back(r);
            stimValid.push_back(v);
            stimCode.push_back(c);
        end
    endtask

    task automatic addPress(input logic [3:0] c, input int hold, input int gap);
        addCycles(1'b1, 1'b1, c, hold);
        addCycles(1'b1, 1'b0, c, gap);
    endtask

    task automatic applyKey(input logic [3:0] c, output logic ovf);
        ovf = 1'b0;
        if (c <= 4'd9) begin
            if (bufQ.size() < 8) bufQ.push_front(int'(c));
            else ovf = 1'b1;
        end else if (c == 4'd10) begin
            if (bufQ.size() > 0) void'(bufQ.pop_front());
        end else if (c == 4'd11) begin
            bufQ.delete();
        end
    endtask

    // A press counts once the same code has been seen for D+1 consecutive edges while armed;
    // re-arming needs D+1 consecutive low edges.
    task automatic tick();
        bit         r;
        bit         v;
        logic [3:0] c;
        int         idx;
        logic       acc;
        logic       ovf;
        logic [7:0] lightE;
        logic [3:0] bcdE;
        logic       blankE;
        logic       dpE;
        r = stimRst.pop_front();
        v = stimValid.pop_front();
        c = stimCode.pop_front();
        rst_n     = r;
        key_valid = v;
        key_code  = c;
        @(posedge clk);
        acc = 1'b0;
        ovf = 1'b0;
        if (!r) begin
            bufQ.delete();
            armed  = 1'b1;
            run    = 0;
            low    = 0;
            edges  = 0;
            lightE = 8'h01;
            bcdE   = 4'hF;
            blankE = 1'b1;
            dpE    = 1'b0;
        end else begin
            edges++;
            idx    = (edges / SD) % 8;
            lightE = 8'(1 << idx);
            if (idx < bufQ.size()) begin
                bcdE   = 4'(bufQ[idx]);
                blankE = 1'b0;
            end else begin
                bcdE   = 4'hF;
                blankE = 1'b1;
            end
            dpE = (idx == 0) && (bufQ.size() == 8);
            if (armed) begin
                if (run > 0 && v && c == runCode) run++;
                else if (run > 0) run = 0;
                else if (v) begin
                    run     = 1;
                    runCode = c;
                end
                if (run == D + 1) begin
                    acc   = 1'b1;
                    armed = 1'b0;
                    run   = 0;
                    low   = 0;
                    applyKey(runCode, ovf);
                end
            end else begin
                low = v ? 0 : low + 1;
                if (low == D + 1) armed = 1'b1;
            end
        end
        expVec = {lightE, bcdE, blankE, dpE, acc, ovf, 4'(bufQ.size())};
        #1;
    endtask

    task automatic test_reset();
        addCycles(1'b0, 1'b0, 4'd0, 2);
        while (stimValid.size() > 0) begin
            tick();
            vectors++;
            if (dutVec !== expVec) begin
                miscompares++;
                $display("[TB] FAIL reset: cycle %0d got %h expected %h", edges, dutVec, expVec);
            end
        end
        vectors++;
        if (dutVec !== 20'h01F80) begin
            miscompares++;
            $display("[TB] FAIL reset_values: got %h expected %h", dutVec, 20'h01F80);
        end
        addCycles(1'b1, 1'b0, 4'd0, 40);
        while (stimValid.size() > 0) begin
            tick();
            vectors++;
            if (dutVec !== expVec) begin
                miscompares++;
                $display("[TB] FAIL scan_idle: cycle %0d got %h expected %h", edges, dutVec, expVec);
            end
        end
    endtask

    task automatic test_digits();
        int accepts = 0;
        addPress(4'd1, 20, 20);
        addPress(4'd2, 20, 20);
        addPress(4'd3, 20, 20);
        addCycles(1'b1, 1'b0, 4'd0, 36);
        while (stimValid.size() > 0) begin
            tick();
            if (key_accept === 1'b1) accepts++;
            vectors++;
            if (dutVec !== expVec) begin
                miscompares++;
                $display("[TB] FAIL digits: cycle %0d got %h expected %h", edges, dutVec, expVec);
            end
        end
        vectors++;
        if (accepts !== 3) begin
            miscompares++;
            $display("[TB] FAIL digits_accepts: got %0d expected 3", accepts);
        end
    endtask

    task automatic test_edit();
        addPress(4'd10, 10, 40);
        for (int i = 0; i < 3; i++) addPress(4'd10, 10, 10);
        addPress(4'd4, 10, 40);
        addPress(4'd11, 10, 40);
        addPress(4'd13, 10, 40);
        while (stimValid.size() > 0) begin
            tick();
            vectors++;
            if (dutVec !== expVec) begin
                miscompares++;
                $display("[TB] FAIL edit: cycle %0d got %h expected %h", edges, dutVec, expVec);
            end
        end
    endtask

    task automatic test_glitch();
        int accepts = 0;
        addPress(4'd7, 2, 10);
        addCycles(1'b1, 1'b1, 4'd5, 3);
        addCycles(1'b1, 1'b1, 4'd6, 2);
        addCycles(1'b1, 1'b0, 4'd6, 10);
        addPress(4'd9, 20, 2);
        addPress(4'd9, 18, 20);
        while (stimValid.size() > 0) begin
            tick();
            if (key_accept === 1'b1) accepts++;
            vectors++;
            if (dutVec !== expVec) begin
                miscompares++;
                $display("[TB] FAIL glitch: cycle %0d got %h expected %h", edges, dutVec, expVec);
            end
        end
        vectors++;
        if (accepts !== 1) begin
            miscompares++;
            $display("[TB] FAIL glitch_accepts: got %0d expected 1", accepts);
        end
    endtask

    task automatic test_overflow();
        int ovfs = 0;
        addPress(4'd11, 8, 8);
        for (int i = 0; i < 9; i++) addPress(4'(i), 8, 8);
        addCycles(1'b1, 1'b0, 4'd0, 40);
        while (stimValid.size() > 0) begin
            tick();
            if (overflow === 1'b1) ovfs++;
            vectors++;
            if (dutVec !== expVec) begin
                miscompares++;
                $display("[TB] FAIL overflow: cycle %0d got %h expected %h", edges, dutVec, expVec);
            end
        end
        vectors++;
        if (ovfs !== 1) begin
            miscompares++;
            $display("[TB] FAIL overflow_pulses: got %0d expected 1", ovfs);
        end
    endtask

    task automatic test_reset_held();
        int accepts = 0;
        addPress(4'd11, 8, 8);
        for (int i = 1; i <= 4; i++) addPress(4'(i), 8, 8);
        addCycles(1'b1, 1'b1, 4'd5, 10);
        addCycles(1'b0, 1'b1, 4'd5, 1);
        addCycles(1'b1, 1'b1, 4'd5, 12);
        addCycles(1'b1, 1'b0, 4'd5, 10);
        while (stimValid.size() > 0) begin
            tick();
            if (key_accept === 1'b1) accepts++;
            vectors++;
            if (dutVec !== expVec) begin
                miscompares++;
                $display("[TB] FAIL reset_held: cycle %0d got %h expected %h", edges, dutVec, expVec);
            end
        end
        vectors++;
        if (accepts !== 7) begin
            miscompares++;
            $display("[TB] FAIL reset_held_accepts: got %0d expected 7", accepts);
        end
    endtask

    task automatic test_random();
        logic [3:0] c;
        int         hold;
        for (int p = 0; p < 60; p++) begin
            c    = 4'($urandom_range(0, 15));
            hold = $urandom_range(1, 14);
            if ($urandom_range(0, 29) == 0) addCycles(1'b0, 1'b1, c, 1);
            for (int k = 0; k < hold; k++) begin
                if ($urandom_range(0, 11) == 0) c = 4'($urandom_range(0, 15));
                addCycles(1'b1, $urandom_range(0, 9) != 0, c, 1);
            end
            addCycles(1'b1, 1'b0, c, $urandom_range(1, 10));
        end
        while (stimValid.size() > 0) begin
            tick();
            vectors++;
            if (dutVec !== expVec) begin
                miscompares++;
                $display("[TB] FAIL random: cycle %0d got %h expected %h", edges, dutVec, expVec);
            end
        end
    endtask

    initial begin
        test_reset();
        test_digits();
        test_edit();
        test_glitch();
        test_overflow();
        test_reset_held();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
